// File: rtl/systolic_pq_array.sv
// Systolic min-priority queue: a chain of sort3 cells evaluated on alternating phases.
// Optional overflow detection on the guard cell is enabled by defining SYSTOLIC_PQ_OVF_EN.
module systolic_pq_array #(
    parameter int KW    = 8,
    parameter int VW    = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KW+VW-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [KW+VW-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
`ifdef SYSTOLIC_PQ_OVF_EN
    output logic                       ovf,
`endif
    output logic                       full
);

    localparam int EW = KW + VW;
    localparam int SW = EW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] INV = {SW{1'b0}};

    // Slot layout is {valid, key, value}; an invalid slot orders as +infinity.
    function automatic logic slot_le(input logic [SW-1:0] x, input logic [SW-1:0] y);
        return {~x[SW-1], x[EW-1:VW]} <= {~y[SW-1], y[EW-1:VW]};
    endfunction

    function automatic logic [3*SW-1:0] sort3(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic [SW-1:0] z);
        logic [SW-1:0] lo;
        logic [SW-1:0] hi;
        logic [SW-1:0] mid;
        logic [SW-1:0] top;
        lo = slot_le(x, y) ? x : y;
        hi = slot_le(x, y) ? y : x;
        if (slot_le(hi, z)) begin
            mid = hi;
            top = z;
        end else begin
            mid = z;
            top = hi;
        end
        if (slot_le(lo, mid)) begin
            return {lo, mid, top};
        end else begin
            return {mid, lo, top};
        end
    endfunction

    logic [SW-1:0]   a_q [0:DEPTH];
    logic [SW-1:0]   a_d [0:DEPTH];
    logic [SW-1:0]   b_q [0:DEPTH];
    logic [SW-1:0]   b_d [0:DEPTH];
    logic [3*SW-1:0] sort_s [0:DEPTH-1];
    logic [SW-1:0]   guard_mn_s;
    logic            phase_q, phase_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            push_s, pop_s;
    logic            in_ready_s, out_valid_s;

    assign in_ready_s  = phase_q && (!full_q || out_ready);
    assign out_valid_s = phase_q && a_q[0][SW-1];
    assign push_s      = in_valid && in_ready_s;
    assign pop_s       = out_valid_s && out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_valid_s ? a_q[0][EW-1:0] : {EW{1'b0}};
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;

    // Sort results of every non-guard cell; the guard only keeps the smaller of its two slots.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sort_s[i] = sort3(a_q[i], b_q[i], a_q[i+1]);
        end
        guard_mn_s = slot_le(a_q[DEPTH], b_q[DEPTH]) ? a_q[DEPTH] : b_q[DEPTH];
    end

    // Each slot is written either by its own cell or by its left neighbour, whichever has the phase.
    always_comb begin
        phase_d = ~phase_q;
        if (!phase_q) begin
            a_d[0] = sort_s[0][3*SW-1:2*SW];
            b_d[0] = INV;
        end else begin
            a_d[0] = pop_s ? INV : a_q[0];
            b_d[0] = push_s ? {1'b1, in_data} : b_q[0];
        end
        for (int j = 1; j < DEPTH; j++) begin
            if (phase_q == 1'(j % 2)) begin
                a_d[j] = sort_s[j][3*SW-1:2*SW];
                b_d[j] = INV;
            end else begin
                a_d[j] = sort_s[j-1][2*SW-1:SW];
                b_d[j] = sort_s[j-1][SW-1:0];
            end
        end
        if (phase_q == 1'(DEPTH % 2)) begin
            a_d[DEPTH] = guard_mn_s;
            b_d[DEPTH] = INV;
        end else begin
            a_d[DEPTH] = sort_s[DEPTH-1][2*SW-1:SW];
            b_d[DEPTH] = sort_s[DEPTH-1][SW-1:0];
        end
    end

    // Occupancy bookkeeping; a replace leaves the count untouched.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == {CW{1'b0}});
        full_d  = (count_d == CW'(DEPTH));
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            count_q <= {CW{1'b0}};
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            for (int j = 0; j <= DEPTH; j++) begin
                a_q[j] <= INV;
                b_q[j] <= INV;
            end
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef SYSTOLIC_PQ_OVF_EN
    logic ovf_q, ovf_d;
    logic discard_s;

    // Mx of the guard is always invalid, so a discard means both guard slots were valid.
    always_comb begin
        discard_s = (phase_q == 1'(DEPTH % 2)) && a_q[DEPTH][SW-1] && b_q[DEPTH][SW-1];
        ovf_d     = ovf_q | discard_s;
    end

    // Sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_systolic_pq_array.sv
// Directed and model-checked bench for systolic_pq_array with default parameters.
module tb_systolic_pq_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] in_data = 12'h000;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic [3:0]  count;
    logic        empty;
    logic        full;
`ifdef SYSTOLIC_PQ_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_ir;
    logic        s_ov;
    logic [11:0] s_od;

    systolic_pq_array #(.KW(8), .VW(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .empty(empty),
`ifdef SYSTOLIC_PQ_OVF_EN
        .ovf(ovf),
`endif
        .full(full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called 1ns into a host (phase 1) cycle; returns 1ns into the next host cycle.
    task automatic slot(input logic push, input logic [11:0] d, input logic pop);
        in_valid = push; in_data = d; out_ready = pop;
        #1;
        s_ir = in_ready; s_ov = out_valid; s_od = out_data;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; in_data = 12'h000;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_c1: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0 || out_data !== 12'h000) begin n_fail++; $display("FAIL reset_out: got %b/%h expected 0/000", out_valid, out_data); end
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_c2: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_c2: got %b expected 0", out_valid); end
    endtask

    task automatic test_basic();
        logic [11:0] exp_v [3];
        exp_v[0] = 12'h102; exp_v[1] = 12'h203; exp_v[2] = 12'h301;
        slot(1'b1, 12'h301, 1'b0);
        slot(1'b1, 12'h102, 1'b0);
        slot(1'b1, 12'h203, 1'b0);
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", count); end
        for (int i = 0; i < 3; i++) begin
            slot(1'b0, 12'h000, 1'b1);
            n_checks++; if (s_ov !== 1'b1 || s_od !== exp_v[i]) begin n_fail++; $display("FAIL basic_pop%0d: got %b/%h expected 1/%h", i, s_ov, s_od, exp_v[i]); end
        end
        n_checks++; if (empty !== 1'b1 || count !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got empty=%b count=%0d ov=%b expected 1/0/0", empty, count, out_valid); end
    endtask

    task automatic test_full();
        logic [7:0]  k;
        logic [11:0] e;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            k = 8'h80 - 8'(i * 16);
            slot(1'b1, {k, 4'(i)}, 1'b0);
        end
        n_checks++; if (full !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL full_flags: got full=%b count=%0d expected 1/8", full, count); end
        slot(1'b1, 12'h055, 1'b0);
        n_checks++; if (s_ir !== 1'b0) begin n_fail++; $display("FAIL full_backpressure: got in_ready=%b expected 0", s_ir); end
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count_hold: got %0d expected 8", count); end
        for (int i = 0; i < 8; i++) begin
            k = 8'(16 * (i + 1));
            e = {k, 4'(7 - i)};
            slot(1'b0, 12'h000, 1'b1);
            n_checks++; if (s_ov !== 1'b1 || s_od !== e) begin n_fail++; $display("FAIL full_pop%0d: got %b/%h expected 1/%h", i, s_ov, s_od, e); end
        end
        n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL full_drain: got count=%0d empty=%b expected 0/1", count, empty); end
    endtask

    task automatic test_replace();
        apply_reset();
        for (int i = 0; i < 8; i++) slot(1'b1, {8'(16 * (i + 1)), 4'h0}, 1'b0);
        slot(1'b1, 12'h05F, 1'b1);
        n_checks++; if (s_ir !== 1'b1) begin n_fail++; $display("FAIL replace_ready: got %b expected 1", s_ir); end
        n_checks++; if (s_od !== 12'h100) begin n_fail++; $display("FAIL replace_out: got %h expected 100", s_od); end
        n_checks++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL replace_count: got %0d/%b expected 8/1", count, full); end
        slot(1'b0, 12'h000, 1'b1);
        n_checks++; if (s_od !== 12'h05F) begin n_fail++; $display("FAIL replace_next: got %h expected 05F", s_od); end
        n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL replace_count2: got %0d expected 7", count); end
    endtask

    task automatic test_ties();
        logic [11:0] x, y;
        apply_reset();
        slot(1'b1, 12'hFFA, 1'b0);
        slot(1'b1, 12'hFFB, 1'b0);
        slot(1'b1, 12'h00C, 1'b0);
        slot(1'b0, 12'h000, 1'b1);
        n_checks++; if (s_od !== 12'h00C) begin n_fail++; $display("FAIL ties_first: got %h expected 00C", s_od); end
        slot(1'b0, 12'h000, 1'b1); x = s_od;
        slot(1'b0, 12'h000, 1'b1); y = s_od;
        n_checks++; if (!((x === 12'hFFA && y === 12'hFFB) || (x === 12'hFFB && y === 12'hFFA))) begin n_fail++; $display("FAIL ties_pair: got %h,%h expected FFA,FFB in any order", x, y); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ties_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        slot(1'b1, 12'h301, 1'b0);
        slot(1'b1, 12'h102, 1'b0);
        slot(1'b1, 12'h203, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (count !== 4'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL midreset: got count=%0d ov=%b empty=%b expected 0/0/1", count, out_valid, empty); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_slot: got ov=%b ir=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_random();
        logic [11:0] mq [$];
        logic        push, pop, exp_ir, exp_ov;
        logic [7:0]  k, mink;
        logic [11:0] d;
        int          idx;
        apply_reset();
        for (int n = 0; n < 2000; n++) begin
            push = ($urandom_range(0, 3) != 0);
            pop  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       k = 8'h00;
                1:       k = 8'hFF;
                default: k = 8'($urandom_range(0, 255));
            endcase
            d = {k, 4'($urandom_range(0, 15))};
            exp_ir = (mq.size() < 8) || pop;
            exp_ov = (mq.size() > 0);
            n_checks++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL rand_count@%0d: got %0d expected %0d", n, count, mq.size()); end
            slot(push, d, pop);
            n_checks++; if (s_ir !== exp_ir || s_ov !== exp_ov) begin n_fail++; $display("FAIL rand_hs@%0d: got ir=%b ov=%b expected %b/%b", n, s_ir, s_ov, exp_ir, exp_ov); end
            if (exp_ov) begin
                mink = 8'hFF;
                foreach (mq[i]) if (mq[i][11:4] < mink) mink = mq[i][11:4];
                n_checks++; if (s_od[11:4] !== mink) begin n_fail++; $display("FAIL rand_min@%0d: got key %h expected %h", n, s_od[11:4], mink); end
                if (pop) begin
                    idx = -1;
                    foreach (mq[i]) if (idx < 0 && mq[i] === s_od) idx = i;
                    n_checks++; if (idx < 0) begin n_fail++; $display("FAIL rand_entry@%0d: got %h expected an entry with key %h", n, s_od, mink); end
                    if (idx < 0) foreach (mq[i]) if (idx < 0 && mq[i][11:4] == mink) idx = i;
                    mq.delete(idx);
                end
            end else begin
                n_checks++; if (s_od !== 12'h000) begin n_fail++; $display("FAIL rand_zero@%0d: got %h expected 000", n, s_od); end
            end
            if (push && exp_ir) mq.push_back(d);
        end
`ifdef SYSTOLIC_PQ_OVF_EN
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rand_ovf: got %b expected 0", ovf); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_replace();
        test_ties();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
